// File: rtl/ambilight_led_tx_if.sv
// ambilight_led_tx_if: bus between the border-averaging stage (master) and
// the ambilight strip serializer (slave). Carries the colour framebuffer,
// the delayed vsync and the serializer status/strip outputs.
// Build option LED_BRIGHTNESS_EN adds the global brightness byte.
interface ambilight_led_tx_if #(
   parameter int NLEDS = 60
) ();
   logic                  frame_vsync;
   logic [24*NLEDS-1:0]   framebuffer;
`ifdef LED_BRIGHTNESS_EN
   logic [7:0]            brightness;
`endif
   logic                  led_dout;
   logic                  busy;
   logic                  frame_sent;
   logic                  overrun;

`ifdef LED_BRIGHTNESS_EN
   modport master (
      output frame_vsync, framebuffer, brightness,
      input  led_dout, busy, frame_sent, overrun
   );
   modport slave (
      input  frame_vsync, framebuffer, brightness,
      output led_dout, busy, frame_sent, overrun
   );
`else
   modport master (
      output frame_vsync, framebuffer,
      input  led_dout, busy, frame_sent, overrun
   );
   modport slave (
      input  frame_vsync, framebuffer,
      output led_dout, busy, frame_sent, overrun
   );
`endif
endinterface

// File: rtl/ambilight_led_tx.sv
// ambilight_led_tx: serializes NLEDS 24-bit colour words into a WS2812-class
// single-wire LED strip. A rising edge of frame_vsync snapshots the whole
// framebuffer, sends every LED as G,R,B MSB-first, then holds the line low
// for T_RESET cycles to latch the strip. Reset always ends in a full gap.
// Build option LED_BRIGHTNESS_EN: adds a brightness input that scales every
// colour byte by (brightness+1)/256, sampled once per frame at LOAD.
module ambilight_led_tx #(
   parameter int NLEDS   = 60,
   parameter int T_BIT   = 93,
   parameter int T0H     = 30,
   parameter int T1H     = 59,
   parameter int T_RESET = 6000
) (
   input  logic              clk_pixel,
   input  logic              rst_n,
   ambilight_led_tx_if.slave bus
);

   localparam int FBW = 24 * NLEDS;
   localparam int BW  = (T_BIT   > 1) ? $clog2(T_BIT)   : 1;
   localparam int GW  = (T_RESET > 1) ? $clog2(T_RESET) : 1;
   localparam int LW  = (NLEDS   > 1) ? $clog2(NLEDS)   : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(T_BIT - 1);
   localparam logic [BW-1:0] HI_ONE   = BW'(T1H);
   localparam logic [BW-1:0] HI_ZERO  = BW'(T0H);
   localparam logic [GW-1:0] GAP_LAST = GW'(T_RESET - 1);
   localparam logic [LW-1:0] LED_LAST = LW'(NLEDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_BIT  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Framebuffer word is {B,R,G}; the strip wants G first, then R, then B.
   function automatic logic [23:0] wire_order(input logic [23:0] w);
      return {w[7:0], w[15:8], w[23:16]};
   endfunction

`ifdef LED_BRIGHTNESS_EN
   // (c * (br+1)) >> 8 ; br = 255 leaves the byte unchanged.
   function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] br);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, br} + 16'd1);
      return p[15:8];
   endfunction

   function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] br);
      return {scale_byte(w[23:16], br), scale_byte(w[15:8], br), scale_byte(w[7:0], br)};
   endfunction
`endif

   state_t          state_q, state_d;
   logic            vsync_q;
   logic            pending_q, pending_d;
   logic            rst_gap_q, rst_gap_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [4:0]      bit_idx_q, bit_idx_d;
   logic [LW-1:0]   led_idx_q, led_idx_d;
   logic [23:0]     sr_q, sr_d;
   logic [FBW-1:0]  shadow_q, shadow_d;
   logic            led_dout_q, led_dout_d;
   logic            busy_q, busy_d;
   logic            frame_sent_q, frame_sent_d;
   logic            overrun_q, overrun_d;
   logic            edge_s;
   logic [23:0]     load_word_s;
   logic [23:0]     next_word_s;

`ifdef LED_BRIGHTNESS_EN
   logic [7:0]      bright_q, bright_d;
   assign load_word_s = wire_order(scale_word(bus.framebuffer[23:0], bus.brightness));
   assign next_word_s = wire_order(scale_word(shadow_q[23:0], bright_q));
`else
   assign load_word_s = wire_order(bus.framebuffer[23:0]);
   assign next_word_s = wire_order(shadow_q[23:0]);
`endif

   assign edge_s = bus.frame_vsync & ~vsync_q;

   // Next-state, datapath and output decode for the serializer FSM.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      rst_gap_d    = rst_gap_q;
      gap_cnt_d    = gap_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      bit_idx_d    = bit_idx_q;
      led_idx_d    = led_idx_q;
      sr_d         = sr_q;
      shadow_d     = shadow_q;
      led_dout_d   = 1'b0;
      frame_sent_d = 1'b0;
      overrun_d    = 1'b0;
`ifdef LED_BRIGHTNESS_EN
      bright_d     = bright_q;
`endif

      // Vsync edges arriving while busy collapse into one pending frame.
      if (edge_s && (state_q != ST_IDLE)) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end else begin
         pending_d = pending_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (edge_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_LOAD: begin
            // Word 0 goes straight to the shifter; the shadow keeps the rest.
            shadow_d  = bus.framebuffer >> 32'd24;
            sr_d      = load_word_s;
            led_idx_d = '0;
            bit_idx_d = 5'd23;
            bit_cnt_d = '0;
`ifdef LED_BRIGHTNESS_EN
            bright_d  = bus.brightness;
`endif
            state_d   = ST_BIT;
         end

         ST_BIT: begin
            led_dout_d = (bit_cnt_q < (sr_q[23] ? HI_ONE : HI_ZERO));
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 5'd0) begin
                  if (led_idx_q == LED_LAST) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = '0;
                  end else begin
                     led_idx_d = led_idx_q + 1'b1;
                     sr_d      = next_word_s;
                     shadow_d  = shadow_q >> 32'd24;
                     bit_idx_d = 5'd23;
                  end
               end else begin
                  sr_d      = {sr_q[22:0], 1'b0};
                  bit_idx_d = bit_idx_q - 5'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               // The gap forced by reset latches nothing, so no frame_sent.
               frame_sent_d = ~rst_gap_q;
               rst_gap_d    = 1'b0;
               if (pending_d) begin
                  pending_d = 1'b0;
                  state_d   = ST_LOAD;
               end else begin
                  state_d   = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset lands in a full latch gap.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_GAP;
         vsync_q      <= 1'b0;
         pending_q    <= 1'b0;
         rst_gap_q    <= 1'b1;
         gap_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         bit_idx_q    <= 5'd0;
         led_idx_q    <= '0;
         sr_q         <= 24'd0;
         shadow_q     <= '0;
         led_dout_q   <= 1'b0;
         busy_q       <= 1'b1;
         frame_sent_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef LED_BRIGHTNESS_EN
         bright_q     <= 8'hFF;
`endif
      end else begin
         state_q      <= state_d;
         vsync_q      <= bus.frame_vsync;
         pending_q    <= pending_d;
         rst_gap_q    <= rst_gap_d;
         gap_cnt_q    <= gap_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         led_idx_q    <= led_idx_d;
         sr_q         <= sr_d;
         shadow_q     <= shadow_d;
         led_dout_q   <= led_dout_d;
         busy_q       <= busy_d;
         frame_sent_q <= frame_sent_d;
         overrun_q    <= overrun_d;
`ifdef LED_BRIGHTNESS_EN
         bright_q     <= bright_d;
`endif
      end
   end

   assign bus.led_dout   = led_dout_q;
   assign bus.busy       = busy_q;
   assign bus.frame_sent = frame_sent_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ambilight_led_tx.sv
// tb_ambilight_led_tx: scoreboard bench for ambilight_led_tx with a small
// strip (2 LEDs, 6-cycle bits, 10-cycle gap). Expected bits are pushed when a
// frame is requested and popped as the line monitor decodes each high pulse.
module tb_ambilight_led_tx;

   localparam int NLEDS     = 2;
   localparam int T_BIT     = 6;
   localparam int T0H       = 2;
   localparam int T1H       = 4;
   localparam int T_RESET   = 10;
   localparam int FBW       = 24 * NLEDS;
   localparam int FRAME_CYC = NLEDS * 24 * T_BIT + T_RESET + 1;

   logic clk_pixel = 1'b0;
   logic rst_n;

   ambilight_led_tx_if #(.NLEDS(NLEDS)) bus ();

   ambilight_led_tx #(
      .NLEDS   (NLEDS),
      .T_BIT   (T_BIT),
      .T0H     (T0H),
      .T1H     (T1H),
      .T_RESET (T_RESET)
   ) dut (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   bit   sb[$];
   int   fs_count = 0;
   int   ov_count = 0;
   int   idle_cnt = 0;
   int   idle_at_fs = 0;
   int   last_fs_cyc = 0;
   int   first_rise_exp = 0;
   int   last_rise = 0;
   int   hi_cnt = 0;
   int   bits_in_frame = 0;
   logic prev_led = 1'b0;

   always @(posedge clk_pixel) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_scale(input logic [7:0] c, input logic [7:0] br);
      int p;
      p = int'(c) * (int'(br) + 1);
      return 8'(p >> 8);
   endfunction

   task automatic push_frame(input logic [FBW-1:0] fb, input logic [7:0] br);
      logic [23:0] w;
      logic [7:0]  col [3];
      for (int j = 0; j < NLEDS; j++) begin
         w = fb[24*j +: 24];
         col[0] = model_scale(w[7:0], br);
         col[1] = model_scale(w[15:8], br);
         col[2] = model_scale(w[23:16], br);
         for (int c = 0; c < 3; c++) begin
            for (int b = 7; b >= 0; b--) begin
               sb.push_back(col[c][b]);
            end
         end
      end
   endtask

   task automatic pulse_vsync(output int e);
      @(posedge clk_pixel); #1;
      bus.frame_vsync = 1'b1;
      e = cyc + 1;
      @(posedge clk_pixel); #1;
      bus.frame_vsync = 1'b0;
   endtask

   task automatic wait_fs(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (fs_count < target && n < budget) begin
         @(negedge clk_pixel);
         n++;
      end
      check(tag, fs_count, target);
   endtask

   task automatic check_reset_gap();
      int fs0;
      fs0 = fs_count;
      for (int i = 0; i < T_RESET; i++) begin
         @(negedge clk_pixel);
         check("gap_busy", int'(bus.busy), 1);
         check("gap_led", int'(bus.led_dout), 0);
      end
      @(negedge clk_pixel);
      check("gap_then_idle", int'(bus.busy), 0);
      repeat (3) @(negedge clk_pixel);
      check("no_fs_after_reset_gap", fs_count, fs0);
   endtask

   // Line monitor: decodes high pulses into bits and tracks status pulses.
   initial begin
      forever begin
         @(negedge clk_pixel);
         if (!rst_n) begin
            prev_led      = 1'b0;
            hi_cnt        = 0;
            bits_in_frame = 0;
            last_rise     = 0;
            sb.delete();
         end else begin
            if (bus.led_dout) begin
               if (!prev_led) begin
                  if (first_rise_exp != 0) begin
                     check("first_high_cycle", cyc, first_rise_exp);
                     first_rise_exp = 0;
                  end
                  if (last_rise != 0 && (cyc - last_rise) <= 2 * T_BIT) begin
                     check("bit_period", cyc - last_rise, T_BIT);
                  end
                  last_rise = cyc;
                  hi_cnt    = 1;
               end else begin
                  hi_cnt++;
               end
            end else if (prev_led) begin
               check("sb_nonempty", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  bit eb;
                  eb = sb.pop_front();
                  check("bit_high_width", hi_cnt, eb ? T1H : T0H);
               end
               bits_in_frame++;
            end
            prev_led = bus.led_dout;
            if (bus.frame_sent) begin
               fs_count++;
               last_fs_cyc = cyc;
               idle_at_fs  = idle_cnt;
               check("bits_per_frame", bits_in_frame, NLEDS * 24);
               bits_in_frame = 0;
            end
            if (bus.overrun) ov_count++;
            if (!bus.busy && !bus.frame_sent) idle_cnt++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      int e2;
      int n;
      int ov0;
      int idle0;
      int fs0;
      logic [FBW-1:0] fb;

      rst_n            = 1'b0;
      bus.frame_vsync  = 1'b0;
      bus.framebuffer  = '0;
`ifdef LED_BRIGHTNESS_EN
      bus.brightness   = 8'hFF;
`endif

      // Reset values while held in reset.
      @(negedge clk_pixel);
      check("rst_led", int'(bus.led_dout), 0);
      check("rst_busy", int'(bus.busy), 1);
      check("rst_frame_sent", int'(bus.frame_sent), 0);
      check("rst_overrun", int'(bus.overrun), 0);
      repeat (2) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      check_reset_gap();

      // Single frame: LED0 green, LED1 blue.
      fb = {24'hFF0000, 24'h0000FF};
      bus.framebuffer = fb;
      push_frame(fb, 8'hFF);
      pulse_vsync(e);
      first_rise_exp = e + 2;
      wait_fs("frame1_sent", 1, FRAME_CYC + 20);
      check("frame1_latency", last_fs_cyc - e, FRAME_CYC);
      check("frame1_sb_drained", sb.size(), 0);

      // Framebuffer changes after LOAD must not leak into the frame.
      fb = {24'h5A3C96, 24'hC3A5E1};
      bus.framebuffer = fb;
      push_frame(fb, 8'hFF);
      pulse_vsync(e);
      repeat (60) @(posedge clk_pixel);
      #1;
      bus.framebuffer = ~fb;
      wait_fs("shadow_frame_sent", 2, FRAME_CYC + 20);
      check("shadow_sb_drained", sb.size(), 0);

      // Two edges while busy: one pending frame, one overrun, back-to-back.
      fb = {24'h123456, 24'hABCDEF};
      bus.framebuffer = fb;
      push_frame(fb, 8'hFF);
      push_frame(fb, 8'hFF);
      ov0 = ov_count;
      pulse_vsync(e);
      idle0 = idle_cnt;
      repeat (20) @(posedge clk_pixel);
      pulse_vsync(e2);
      repeat (20) @(posedge clk_pixel);
      pulse_vsync(e2);
      repeat (3) @(negedge clk_pixel);
      check("overrun_pulse", ov_count - ov0, 1);
      wait_fs("pend_frame_a_sent", 3, FRAME_CYC + 20);
      check("pend_frame_a_latency", last_fs_cyc - e, FRAME_CYC);
      wait_fs("pend_frame_b_sent", 4, FRAME_CYC + 20);
      check("pend_frame_b_latency", last_fs_cyc - e, 2 * FRAME_CYC);
      check("no_idle_between", idle_at_fs - idle0, 0);
      repeat (FRAME_CYC) @(negedge clk_pixel);
      check("no_extra_frame", fs_count, 4);
      check("overrun_total", ov_count - ov0, 1);
      check("pend_sb_drained", sb.size(), 0);

      // Reset in the middle of a high phase.
      fb = {24'h00FF00, 24'h0F0F0F};
      bus.framebuffer = fb;
      push_frame(fb, 8'hFF);
      pulse_vsync(e);
      repeat (40) @(posedge clk_pixel);
      n = 0;
      do begin
         @(negedge clk_pixel);
         n++;
      end while (!bus.led_dout && n < 20);
      check("midbit_high_seen", int'(bus.led_dout), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midbit_rst_led", int'(bus.led_dout), 0);
      check("midbit_rst_busy", int'(bus.busy), 1);
      repeat (2) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      check_reset_gap();
      check("midbit_sb_flushed", sb.size(), 0);
      fs0 = fs_count;
      fb = {24'hF00F55, 24'h817E00};
      bus.framebuffer = fb;
      push_frame(fb, 8'hFF);
      pulse_vsync(e);
      first_rise_exp = e + 2;
      wait_fs("post_rst_frame_sent", fs0 + 1, FRAME_CYC + 20);
      check("post_rst_latency", last_fs_cyc - e, FRAME_CYC);
      check("post_rst_sb_drained", sb.size(), 0);

`ifdef LED_BRIGHTNESS_EN
      // Half brightness; a change after LOAD must not affect this frame.
      fs0 = fs_count;
      fb = {24'hFFFFFF, 24'h0000FF};
      bus.framebuffer = fb;
      bus.brightness  = 8'h7F;
      push_frame(fb, 8'h7F);
      pulse_vsync(e);
      repeat (5) @(posedge clk_pixel);
      #1;
      bus.brightness = 8'h00;
      wait_fs("bright_7f_sent", fs0 + 1, FRAME_CYC + 20);
      check("bright_7f_sb_drained", sb.size(), 0);
      bus.brightness = 8'hFF;
      push_frame(fb, 8'hFF);
      pulse_vsync(e);
      wait_fs("bright_ff_sent", fs0 + 2, FRAME_CYC + 20);
      check("bright_ff_sb_drained", sb.size(), 0);
`endif

      check("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
